// File: rtl/hc194_seq_pkg.sv
// Shared types and constants for the hc194 command sequencer.
// Build option: define HC194_SEQ_ROT_EN to enable the ROT (rotate) command.
package hc194_seq_pkg;

  localparam int unsigned NIB_W  = 4;
  localparam int unsigned MODE_W = 2;

  // Command opcodes as presented on cmd_op
  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SHR  = 2'b01,
    OP_SHL  = 2'b10,
    OP_ROT  = 2'b11
  } op_e;

  // Mode select values driven onto the shift register's S pins
  localparam logic [MODE_W-1:0] MODE_HOLD = 2'b00;
  localparam logic [MODE_W-1:0] MODE_SHR  = 2'b01;
  localparam logic [MODE_W-1:0] MODE_SHL  = 2'b10;
  localparam logic [MODE_W-1:0] MODE_LOAD = 2'b11;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10,
    ST_FIN  = 2'b11
  } state_e;

endpackage

// File: rtl/hc194_seq_cnt.sv
// Loadable down counter for the shift run length, with a registered last flag (value==1).
module hc194_seq_cnt #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [CNT_W-1:0] val_i,
  output logic             last_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load wins over decrement; never wraps below zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register and last flag kept in step with it
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q  <= '0;
      last_o <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      last_o <= (cnt_d == CNT_W'(1));
    end
  end

endmodule

// File: rtl/hc194_seq.sv
// Command sequencer driving mode/data/serial pins of a 4-bit universal shift register.
// Build option: HC194_SEQ_ROT_EN enables ROT; otherwise ROT completes at once with err.
module hc194_seq
  import hc194_seq_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic              Clk,
  input  logic              MR,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [NIB_W-1:0]  cmd_data,
  input  logic [CNT_W-1:0]  cmd_count,
  input  logic              cmd_fill,
  input  logic [NIB_W-1:0]  q_fb,
  output logic [MODE_W-1:0] S,
  output logic [NIB_W-1:0]  D,
  output logic              DSR,
  output logic              DSL,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e             state_q, state_d;
  op_e                op_q, op_d;
  logic [NIB_W-1:0]   data_q, data_d;
  logic               fill_q, fill_d;
  logic [MODE_W-1:0]  s_q, s_d;
  logic [NIB_W-1:0]   d_q, d_d;
  logic               dsr_q, dsr_d;
  logic               dsl_q, dsl_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               ready_q, ready_d;
  logic               accept_c;
  logic               cnt_load_c;
  logic               cnt_dec_c;
  logic               cnt_last;
  logic               unused_q_fb;

  assign accept_c    = cmd_valid & ready_q;
  assign unused_q_fb = ^q_fb;

  // Run-length counter
  hc194_seq_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk_i   (Clk),
    .rst_n_i (MR),
    .load_i  (cnt_load_c),
    .dec_i   (cnt_dec_c),
    .val_i   (cmd_count),
    .last_o  (cnt_last)
  );

  // Next state, latched command fields and next registered outputs
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    data_d     = data_q;
    fill_d     = fill_q;
    cnt_load_c = 1'b0;
    cnt_dec_c  = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    s_d        = MODE_HOLD;
    d_d        = '0;
    dsr_d      = 1'b0;
    dsl_d      = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_FIN: begin
        if (accept_c) begin
          op_d       = op_e'(cmd_op);
          data_d     = cmd_data;
          fill_d     = cmd_fill;
          cnt_load_c = 1'b1;
          if (op_e'(cmd_op) == OP_LOAD) begin
            state_d = ST_LOAD;
`ifndef HC194_SEQ_ROT_EN
          end else if (op_e'(cmd_op) == OP_ROT) begin
            // Rotate not built: finish immediately and flag it
            state_d = ST_FIN;
            err_d   = 1'b1;
`endif
          end else if (cmd_count == '0) begin
            state_d = ST_FIN;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        state_d = ST_FIN;
        done_d  = 1'b1;
      end
      ST_RUN: begin
        cnt_dec_c = 1'b1;
        if (cnt_last) begin
          state_d = ST_FIN;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d  = (state_d == ST_LOAD) || (state_d == ST_RUN);
    ready_d = (state_d == ST_IDLE) || (state_d == ST_FIN);

    // Pin values for the cycle following this edge
    if (state_d == ST_LOAD) begin
      s_d = MODE_LOAD;
      d_d = data_d;
    end else if (state_d == ST_RUN) begin
      unique case (op_d)
        OP_SHR: begin
          s_d   = MODE_SHR;
          dsr_d = fill_d;
        end
        OP_SHL: begin
          s_d   = MODE_SHL;
          dsl_d = fill_d;
        end
`ifdef HC194_SEQ_ROT_EN
        OP_ROT:  s_d = MODE_SHR;
`endif
        default: s_d = MODE_HOLD;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge Clk or negedge MR) begin
    if (!MR) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LOAD;
      data_q  <= '0;
      fill_q  <= 1'b0;
      s_q     <= MODE_HOLD;
      d_q     <= '0;
      dsr_q   <= 1'b0;
      dsl_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      data_q  <= data_d;
      fill_q  <= fill_d;
      s_q     <= s_d;
      d_q     <= d_d;
      dsr_q   <= dsr_d;
      dsl_q   <= dsl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  assign cmd_ready = ready_q;
  assign S         = s_q;
  assign D         = d_q;
  assign DSL       = dsl_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

`ifdef HC194_SEQ_ROT_EN
  // Rotate feeds the register's top bit straight back into its serial-right input
  assign DSR = ((state_q == ST_RUN) && (op_q == OP_ROT)) ? q_fb[NIB_W-1] : dsr_q;
`else
  assign DSR = dsr_q;
`endif

endmodule

// File: doc/hc194_seq.md
# hc194_seq

Command-driven sequencer that sits directly upstream of the 4-bit universal shift register stage and generates its mode select, parallel data and serial inputs. A single command loads a nibble or shifts left/right a programmed number of times. It reports completion with a one-cycle pulse. Register contents are fed back for the optional rotate operation.

## Interface
Parameters:
- CNT_W, 4, width of the shift-count field; the maximum run is 2^CNT_W−1 shifts.

Ports:
- Clk  in  1  single clock, rising edge.
- MR  in  1  reset; asynchronous assert, active-low.
- cmd_valid  in  1  command present; the source holds it until accepted.
- cmd_ready  out  1  sequencer idle, able to accept a command.
- cmd_op  in  2  00 LOAD, 01 SHR, 10 SHL, 11 ROT.
- cmd_data  in  4  parallel nibble, used by LOAD.
- cmd_count  in  CNT_W  number of shifts, used by SHR/SHL/ROT.
- cmd_fill  in  1  serial fill bit, used by SHR/SHL.
- q_fb  in  4  Q from the downstream shift register.
- S  out  2  mode to the register: 00 hold, 01 shift right (Q0←DSR, Qn←Qn−1), 10 shift left (Q3←DSL, Qn←Qn+1), 11 load.
- D  out  4  parallel load data.
- DSR  out  1  serial right input.
- DSL  out  1  serial left input.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle illegal-command pulse.

## Operation
- FSM states: IDLE, LOAD, RUN, FIN.
- IDLE: cmd_ready=1, S=00. On cmd_valid&cmd_ready, latch op, data, count and fill.
  - LOAD → LOAD state.
  - SHR/SHL/ROT with count≠0 → RUN.
  - count=0 → FIN, with no shift issued.
- LOAD: S=11 and D=latched data for exactly one cycle, then → FIN.
- RUN: S=01 for SHR/ROT and S=10 for SHL, held for exactly count cycles.
  - Down counter loads with count and decrements each RUN cycle.
  - Leave RUN on the cycle the counter reads 1 → FIN.
- Serial inputs during RUN:
  - SHR: DSR=fill.
  - SHL: DSL=fill.
  - ROT: DSR=q_fb[3], combinational from q_fb (rotate toward higher index).
  - The unused serial input is driven 0.
- FIN: S=00, done=1 for one cycle, busy=0, cmd_ready=1.
  - A new command can be accepted in FIN, giving back-to-back operation.
  - With no new command, → IDLE.
- busy=1 in LOAD and RUN.
- D=0 outside LOAD. S is never 11 outside LOAD.
- cmd_valid while not ready is ignored. The latched fields are not disturbed.

## Timing
- All outputs registered, except DSR in ROT.
- Command accepted at edge E0:
  - S, D and serial inputs are valid after E0.
  - The register acts at edges E1..En (n=1 for LOAD, n=count for shifts).
  - done is high between En and En+1.
  - For count=0, done is high between E0 and E1.
- Maximum issue rate: one command per n+1 cycles.
- Reset values, forced immediately while MR=0 irrespective of Clk:
  - S=00, D=0, DSR=0, DSL=0, busy=0, done=0, err=0, cmd_ready=0.
  - State=IDLE, counter=0.
- cmd_ready rises on the first edge after MR deasserts.
- Reset mid-RUN: S drops to 00 asynchronously, so no further shift occurs. No done pulse is generated.

## Configuration
- HC194_SEQ_ROT_EN defined: ROT behaves as above.
- HC194_SEQ_ROT_EN undefined:
  - ROT is accepted but goes straight to FIN with err=1 (instead of done) for that one cycle.
  - S stays 00; the register is untouched.
  - q_fb is unused and DSR is never fed back.

## Structure
- Package hc194_seq_pkg holds:
  - op enum (OP_LOAD, OP_SHR, OP_SHL, OP_ROT).
  - mode constants (MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11).
  - FSM state enum.
- Sub-module hc194_seq_cnt: CNT_W-bit loadable down counter with a last flag (value==1). Instantiated once.

## Test plan
- Reset, then LOAD data=4'b1010 → S=11 for 1 cycle, D=1010, done one cycle later. Bench register Q=1010.
- Q=1010, SHR count=2 fill=1 → S=01 for 2 cycles, DSR=1, Q=1011 after. done at E3.
- Q=1011, SHL count=3 fill=0 → S=10 for 3 cycles. Q sequence 0101, 0010, 0001.
- Q=0001, ROT count=5:
  - With macro: Q ends 0010, done.
  - Without macro: err pulse, S stays 00, Q unchanged 0001.
- SHR count=0 → no S≠00 cycle, done at E1. Second command presented during FIN is accepted back-to-back.
- MR asserted during the third cycle of SHL count=8 → S=00, busy=0 immediately. No done pulse. Q frozen at the value reached.
